// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the iterative AES-128 round controller.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_KIDX_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } aes_fsm_e;

endpackage

// File: rtl/add_round_key.sv
// Full-width AddRoundKey: bitwise XOR of a data block with a round key.
module add_round_key
  import aes_pkg::*;
#(
  parameter int unsigned W = AES_BLK_W
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] key,
  output logic [W-1:0] result
);

  assign result = data ^ key;

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 sequencer: whitens the accepted block, then steps the external round
// datapath NR times and presents the ciphertext with a valid/ready handshake.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int unsigned NR    = AES_NR,
  parameter int unsigned BLK_W = AES_BLK_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLK_W-1:0]      plaintext,
  output logic [AES_KIDX_W-1:0] key_idx,
  input  logic [BLK_W-1:0]      round_key,
  output logic [BLK_W-1:0]      rnd_state,
  output logic                  rnd_final,
  input  logic [BLK_W-1:0]      rnd_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W-1:0]      ciphertext,
  output logic                  busy
);

  localparam logic [AES_KIDX_W-1:0] CtrLast = AES_KIDX_W'(NR);
  localparam logic [AES_KIDX_W-1:0] CtrOne  = AES_KIDX_W'(1);

  aes_fsm_e              fsm_q;
  logic [BLK_W-1:0]      state_q;
  logic [AES_KIDX_W-1:0] round_ctr_q;
  logic [BLK_W-1:0]      whitened;

  add_round_key #(
    .W(BLK_W)
  ) u_add_round_key (
    .data  (plaintext),
    .key   (round_key),
    .result(whitened)
  );

  always_comb begin
    in_ready   = (fsm_q == StIdle) | ((fsm_q == StDone) & out_ready);
    out_valid  = (fsm_q == StDone);
    busy       = (fsm_q == StRound) | (fsm_q == StDone);
    key_idx    = (fsm_q == StRound) ? round_ctr_q : '0;
    rnd_final  = (fsm_q == StRound) & (round_ctr_q == CtrLast);
    rnd_state  = state_q;
    ciphertext = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      round_ctr_q <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            state_q     <= whitened;
            round_ctr_q <= CtrOne;
            fsm_q       <= StRound;
          end
        end
        StRound: begin
          // An out-of-range counter can only come from an upset; drop the block.
          if ((round_ctr_q == '0) || (round_ctr_q > CtrLast)) begin
            fsm_q       <= StIdle;
            round_ctr_q <= '0;
          end else begin
            state_q <= rnd_result;
            if (round_ctr_q == CtrLast) begin
              fsm_q <= StDone;
            end else begin
              round_ctr_q <= round_ctr_q + CtrOne;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            if (in_valid) begin
              // key_idx is 0 here, so round_key is the whitening key.
              state_q     <= whitened;
              round_ctr_q <= CtrOne;
              fsm_q       <= StRound;
            end else begin
              fsm_q       <= StIdle;
              round_ctr_q <= '0;
            end
          end
        end
        default: begin
          fsm_q       <= StIdle;
          round_ctr_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: models the AES round datapath and key schedule, and
// scoreboards each accepted block against a reference AES-128 encryption.
module tb_aes_round_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] rnd_state;
  logic         rnd_final;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  aes_round_controller dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .key_idx   (key_idx),
    .round_key (round_key),
    .rnd_state (rnd_state),
    .rnd_final (rnd_final),
    .rnd_result(rnd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic [127:0] exp_q [$];
  logic [127:0] last_ct = '0;
  int           age = -1;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_ct = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // One AES round on a column-major byte array: SubBytes, ShiftRows, [MixColumns], ARK.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = xtime(x0) ^ xtime(x1) ^ x1 ^ x2 ^ x3;
        b[4*c+1] = x0 ^ xtime(x1) ^ xtime(x2) ^ x2 ^ x3;
        b[4*c+2] = x0 ^ x1 ^ xtime(x2) ^ xtime(x3) ^ x3;
        b[4*c+3] = xtime(x0) ^ x0 ^ x1 ^ x2 ^ xtime(x3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = round_fn(s, rk[r], r == 10);
    return s;
  endfunction

  // Behavioural key store and round datapath seen by the DUT.
  always_comb begin
    round_key  = (key_idx <= 4'd10) ? rk[key_idx] : '0;
    rnd_result = round_fn(rnd_state, round_key, rnd_final);
  end

  // Monitor: protocol/trace checks each cycle and scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      age        = -1;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_ciphertext", ciphertext, prev_ct);
      end
      if (age >= 1 && age <= 10) begin
        check("round_key_idx", key_idx, age);
        check("round_rnd_final", rnd_final, age == 10);
        check("round_in_ready", in_ready, 1'b0);
        check("round_out_valid", out_valid, 1'b0);
        check("round_busy", busy, 1'b1);
      end
      if (age == 11) check("latency_out_valid", out_valid, 1'b1);
      if (out_valid) check("done_in_ready", in_ready, out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected no output", ciphertext);
        end else begin
          check("ciphertext", ciphertext, exp_q.pop_front());
        end
        last_ct = ciphertext;
      end
      prev_stall = out_valid & ~out_ready;
      prev_ct    = ciphertext;
      if (in_valid && in_ready) begin
        check("accept_key_idx", key_idx, 4'd0);
        age = 1;
      end else if (age >= 1 && age <= 10) begin
        age++;
      end else begin
        age = -1;
      end
    end
  end

  task automatic send(input logic [127:0] pt, input bit keep);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    plaintext = pt;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(encrypt(pt));
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 60 cycles");
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_key_idx"}, key_idx, 4'd0);
    check({tag, "_rnd_final"}, rnd_final, 1'b0);
    check({tag, "_ciphertext"}, ciphertext, 128'h0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] pt_b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    init_sbox();
    set_key(Key1);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known-answer block; the monitor traces key_idx/rnd_final/latency.
    send(Pt1, 1'b0);
    drain();
    check("vec1_ciphertext", last_ct, Ct1);

    // Backpressure in DONE with a new block pending upstream.
    out_ready = 1'b0;
    send(rand128(), 1'b0);
    wait_out_valid();
    pt_b      = rand128();
    in_valid  = 1'b1;
    plaintext = pt_b;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(pt_b, 1'b0);
    drain();

    // Back-to-back with in_valid and out_ready held high.
    send(rand128(), 1'b1);
    send(rand128(), 1'b0);
    drain();

    // Reset in round 5 aborts the block.
    send(rand128(), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 1'b0);
    set_key(Key1);
    send(Pt1, 1'b0);
    drain();
    check("post_rst_vec1", last_ct, Ct1);

    // All-zero key and plaintext.
    set_key('0);
    send('0, 1'b0);
    drain();
    check("zero_ciphertext", last_ct, Ct0);

    // Random keys, blocks and output stalls.
    for (int n = 0; n < 8; n++) begin
      set_key(rand128());
      out_ready = 1'($urandom_range(0, 1));
      send(rand128(), 1'b0);
      if (!out_ready) begin
        wait_out_valid();
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
